// File: rtl/arp_lookup_seq.sv
// ARP stage behind the LPM lookup: it scans a valid-bit ARP table one entry per cycle and rewrites the L2/L3 header.
// Optional build macro ARP_TTL_EXPIRE_EN: hits with TTL <= 1 go to the CPU queue and are counted separately.
module arp_lookup_seq #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS       = 16,
    parameter int DST_PORT_POS       = 24,
    parameter int NUM_PORTS          = 4,
    parameter int TBL_DEPTH          = 32,
    parameter int TBL_ADDR_W         = 5
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                            S_AXIS_TVALID,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    input  logic                            s_lookup_en,
    input  logic [31:0]                     s_nh_ip,
    input  logic [7:0]                      s_oq,
    input  logic [48*NUM_PORTS-1:0]         port_macs,
    input  logic                            tbl_wr_req,
    input  logic [TBL_ADDR_W-1:0]           tbl_wr_addr,
    input  logic [80:0]                     tbl_wr_data,
    output logic                            tbl_wr_ack,
    input  logic                            tbl_rd_req,
    input  logic [TBL_ADDR_W-1:0]           tbl_rd_addr,
    output logic [80:0]                     tbl_rd_data,
    output logic                            tbl_rd_ack,
    input  logic                            counter_reset,
    output logic [31:0]                     arp_hit_count,
    output logic [31:0]                     arp_miss_count
`ifdef ARP_TTL_EXPIRE_EN
    ,
    output logic [31:0]                     ttl_expired_count
`endif
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam logic [7:0] NP8 = 8'(NUM_PORTS);
    localparam logic [TBL_ADDR_W-1:0] LAST_IDX = TBL_ADDR_W'(TBL_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SEND_HDR, BODY} state_t;

    state_t                 state;
    logic [DW-1:0]          hdr_data;
    logic [DW/8-1:0]        hdr_strb;
    logic [UW-1:0]          hdr_user;
    logic                   hdr_last;
    logic [31:0]            nh;
    logic [7:0]             oq;
    logic [TBL_ADDR_W-1:0]  idx;

    logic [TBL_DEPTH-1:0]   tbl_vld;
    logic [31:0]            tbl_ip  [TBL_DEPTH];
    logic [47:0]            tbl_mac [TBL_DEPTH];

    logic        scan_hit, scan_done, oq_ok, ttl_exp, fwd, miss;
    logic [47:0] sel_mac;
    logic [7:0]  cpu_dst;
    logic [16:0] ck_sum;
    logic [15:0] ck_new;

    always_comb begin
        scan_hit  = (state == SCAN) && tbl_vld[idx] && (tbl_ip[idx] == nh);
        scan_done = (state == SCAN) && (scan_hit || idx == LAST_IDX);
        oq_ok     = oq < NP8;
`ifdef ARP_TTL_EXPIRE_EN
        ttl_exp   = scan_hit && oq_ok && (hdr_data[79:72] <= 8'd1);
`else
        ttl_exp   = 1'b0;
`endif
        fwd       = scan_hit && oq_ok && !ttl_exp;
        miss      = scan_done && !fwd && !ttl_exp;

        sel_mac = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (oq == 8'(p)) sel_mac = port_macs[48*p +: 48];

        // Walk downwards so the lowest even source bit ends up selected.
        cpu_dst = '0;
        for (int p = 3; p >= 0; p--)
            if (hdr_user[SRC_PORT_POS + 2*p]) cpu_dst = 8'(2 << (2*p));

        // TTL sits in the high byte of its checksum word, so -1 on TTL is +0x0100 on the checksum.
        ck_sum = {1'b0, hdr_data[63:48]} + 17'h0100;
        ck_new = ck_sum[15:0] + {15'd0, ck_sum[16]};
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            state          <= IDLE;
            idx            <= '0;
            tbl_vld        <= '0;
            tbl_wr_ack     <= 1'b0;
            tbl_rd_ack     <= 1'b0;
            tbl_rd_data    <= '0;
            arp_hit_count  <= '0;
            arp_miss_count <= '0;
`ifdef ARP_TTL_EXPIRE_EN
            ttl_expired_count <= '0;
`endif
        end else begin
            tbl_wr_ack <= tbl_wr_req;
            tbl_rd_ack <= tbl_rd_req;
            if (tbl_rd_req)
                tbl_rd_data <= {tbl_vld[tbl_rd_addr], tbl_mac[tbl_rd_addr], tbl_ip[tbl_rd_addr]};
            if (tbl_wr_req)
                tbl_vld[tbl_wr_addr] <= tbl_wr_data[80];

            if (counter_reset) begin
                arp_hit_count  <= '0;
                arp_miss_count <= '0;
`ifdef ARP_TTL_EXPIRE_EN
                ttl_expired_count <= '0;
`endif
            end else begin
                if (fwd)  arp_hit_count  <= arp_hit_count + 32'd1;
                if (miss) arp_miss_count <= arp_miss_count + 32'd1;
`ifdef ARP_TTL_EXPIRE_EN
                if (ttl_exp) ttl_expired_count <= ttl_expired_count + 32'd1;
`endif
            end

            case (state)
                IDLE: begin
                    if (S_AXIS_TVALID) begin
                        hdr_data <= S_AXIS_TDATA;
                        hdr_strb <= S_AXIS_TSTRB;
                        hdr_user <= S_AXIS_TUSER;
                        hdr_last <= S_AXIS_TLAST;
                        nh       <= s_nh_ip;
                        oq       <= s_oq;
                        idx      <= '0;
                        state    <= (s_lookup_en && S_AXIS_TUSER[DST_PORT_POS +: 8] == 8'd0)
                                    ? SCAN : SEND_HDR;
                    end
                end
                SCAN: begin
                    idx <= idx + 1'b1;
                    if (scan_done) begin
                        state <= SEND_HDR;
                        if (fwd) begin
                            hdr_data[255:208] <= tbl_mac[idx];
                            hdr_data[207:160] <= sel_mac;
                            hdr_data[79:72]   <= hdr_data[79:72] - 8'd1;
                            hdr_data[63:48]   <= ck_new;
                            hdr_user[DST_PORT_POS +: 8] <= 8'b1 << {oq[1:0], 1'b0};
                        end else begin
                            hdr_user[DST_PORT_POS +: 8] <= cpu_dst;
                        end
                    end
                end
                SEND_HDR: if (M_AXIS_TREADY) state <= hdr_last ? IDLE : BODY;
                BODY:     if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // IP/MAC contents are left unreset so the table can map onto plain RAM.
    always_ff @(posedge AXI_ACLK) begin
        if (tbl_wr_req) begin
            tbl_ip[tbl_wr_addr]  <= tbl_wr_data[31:0];
            tbl_mac[tbl_wr_addr] <= tbl_wr_data[79:32];
        end
    end

    always_comb begin
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = hdr_data;
        M_AXIS_TSTRB  = hdr_strb;
        M_AXIS_TUSER  = hdr_user;
        M_AXIS_TLAST  = hdr_last;
        case (state)
            IDLE:     S_AXIS_TREADY = AXI_RESETN;
            SEND_HDR: M_AXIS_TVALID = AXI_RESETN;
            BODY: begin
                S_AXIS_TREADY = AXI_RESETN & M_AXIS_TREADY;
                M_AXIS_TVALID = AXI_RESETN & S_AXIS_TVALID;
                M_AXIS_TDATA  = S_AXIS_TDATA;
                M_AXIS_TSTRB  = S_AXIS_TSTRB;
                M_AXIS_TUSER  = S_AXIS_TUSER;
                M_AXIS_TLAST  = S_AXIS_TLAST;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arp_lookup_seq.sv
// Bench for arp_lookup_seq: a table/packet model predicts every egress beat, scan latency and counter values.
`timescale 1ns/1ps
module tb_arp_lookup_seq;
    localparam int NP = 4, DEPTH = 32, AW = 5;
    localparam logic [191:0] PMACS = {48'h02AA_0000_0003, 48'h02AA_0000_0002,
                                      48'h02AA_0000_0001, 48'h02AA_0000_0000};
`ifdef ARP_TTL_EXPIRE_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
        bit           hdr;
        int           lat;
    } beat_t;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] S_AXIS_TDATA = '0;
    logic [31:0]  S_AXIS_TSTRB = '0;
    logic [127:0] S_AXIS_TUSER = '0;
    logic S_AXIS_TVALID = 0, S_AXIS_TLAST = 0, S_AXIS_TREADY;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY = 1;
    logic s_lookup_en = 0;
    logic [31:0] s_nh_ip = '0;
    logic [7:0] s_oq = '0;
    logic tbl_wr_req = 0, tbl_rd_req = 0, tbl_wr_ack, tbl_rd_ack, counter_reset = 0;
    logic [AW-1:0] tbl_wr_addr = '0, tbl_rd_addr = '0;
    logic [80:0] tbl_wr_data = '0, tbl_rd_data;
    logic [31:0] arp_hit_count, arp_miss_count;
`ifdef ARP_TTL_EXPIRE_EN
    logic [31:0] ttl_expired_count;
`endif

    arp_lookup_seq #(.C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128), .SRC_PORT_POS(16),
                     .DST_PORT_POS(24), .NUM_PORTS(NP), .TBL_DEPTH(DEPTH), .TBL_ADDR_W(AW)) dut (
        .AXI_ACLK(clk), .AXI_RESETN(rstn),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .s_lookup_en(s_lookup_en), .s_nh_ip(s_nh_ip), .s_oq(s_oq), .port_macs(PMACS),
        .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_wr_ack(tbl_wr_ack),
        .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack),
        .counter_reset(counter_reset), .arp_hit_count(arp_hit_count), .arp_miss_count(arp_miss_count)
`ifdef ARP_TTL_EXPIRE_EN
        , .ttl_expired_count(ttl_expired_count)
`endif
    );

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, last_scan = 0;
    int mh = 0, mm = 0, me = 0;
    bit chk_en = 0, wait_hdr = 0, s_first = 0, rdy_rand = 0;
    beat_t expq[$];
    logic [255:0] last_hdr;
    logic [127:0] last_user;
    bit tv[DEPTH];
    logic [31:0] tip[DEPTH];
    logic [47:0] tmac[DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: first valid matching entry wins; forward only with a real port, else CPU queue.
    function automatic beat_t model_hdr(input beat_t b, input bit len, input logic [31:0] nh,
                                        input logic [7:0] oq, output int scan, output int kind);
        beat_t r = b;
        int hit = -1;
        int ttl, ck;
        kind = 0;
        scan = 0;
        if (!len || b.u[31:24] != 8'd0) return r;
        for (int i = 0; i < DEPTH; i++)
            if (tv[i] && tip[i] == nh) begin hit = i; break; end
        scan = (hit < 0) ? DEPTH : hit + 1;
        ttl = int'(b.d[79:72]);
        if (hit >= 0 && int'(oq) < NP && (!EXP_EN || ttl > 1)) begin
            r.d[255:208] = tmac[hit];
            r.d[207:160] = PMACS[48*int'(oq) +: 48];
            r.d[79:72]   = 8'((ttl + 255) % 256);
            ck = int'(b.d[63:48]) + 256;
            if (ck > 65535) ck -= 65535;
            r.d[63:48]   = 16'(ck);
            r.u[31:24]   = 8'(1 << (2*int'(oq)));
            kind = 1;
        end else begin
            r.u[31:24] = 8'd0;
            for (int p = 0; p < 4; p++)
                if (b.u[16+2*p]) begin r.u[31:24] = 8'(2 << (2*p)); break; end
            kind = (hit >= 0 && int'(oq) < NP) ? 3 : 2;
        end
        return r;
    endfunction

    // Egress checker: every valid beat must equal the queue head; latency checked on each header.
    always @(negedge clk) begin
        beat_t e;
        if (chk_en) begin
            if (S_AXIS_TVALID && S_AXIS_TREADY && s_first) begin
                acc_cyc  = cyc;
                wait_hdr = 1;
            end
            if (M_AXIS_TVALID) begin
                if (expq.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    e = expq[0];
                    if (e.hdr && wait_hdr) begin
                        chk("hdr_latency", cyc - acc_cyc, e.lat);
                        wait_hdr = 0;
                    end
                    chk("tdata", M_AXIS_TDATA, e.d);
                    chk("tuser", M_AXIS_TUSER, e.u);
                    chk("tstrb_tlast", {M_AXIS_TSTRB, M_AXIS_TLAST}, {e.s, e.l});
                    if (M_AXIS_TREADY) begin
                        if (e.hdr) begin last_hdr = M_AXIS_TDATA; last_user = M_AXIS_TUSER; end
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) M_AXIS_TREADY = ($urandom % 4) != 0;
    end

    task automatic wait_hs();
        int n = 0;
        forever begin
            @(negedge clk);
            if (S_AXIS_TREADY) break;
            n++;
            if (n > 300) begin
                errors++; checks++;
                $display("FAIL handshake_timeout: got no TREADY want TREADY within 300 cycles");
                finish_run();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input int nb, input bit len, input logic [31:0] nh, input logic [7:0] oq,
                            input logic [7:0] ttl, input logic [15:0] ck, input logic [7:0] src,
                            input logic [7:0] dst, input bit crst);
        beat_t b, e;
        int scan, kind;
        for (int k = 0; k < nb; k++) begin
            b.d = rnd256(); b.s = $urandom;
            b.u = {$urandom, $urandom, $urandom, $urandom};
            b.l = (k == nb - 1); b.hdr = (k == 0); b.lat = 0;
            if (k == 0) begin
                b.d[79:72] = ttl; b.d[63:48] = ck; b.u[23:16] = src; b.u[31:24] = dst;
                e = model_hdr(b, len, nh, oq, scan, kind);
                e.lat = scan + 1;
                last_scan = scan;
                if (crst) begin mh = 0; mm = 0; me = 0; end
                else if (kind == 1) mh++;
                else if (kind == 2) mm++;
                else if (kind == 3) me++;
            end else e = b;
            expq.push_back(e);
            S_AXIS_TDATA = b.d; S_AXIS_TSTRB = b.s; S_AXIS_TUSER = b.u; S_AXIS_TLAST = b.l;
            S_AXIS_TVALID = 1; s_first = (k == 0);
            s_lookup_en = len; s_nh_ip = nh; s_oq = oq;
            wait_hs();
            s_first = 0;
            if (k == 0 && crst) begin
                counter_reset = 1;
                @(posedge clk); #1;
                counter_reset = 0;
            end
        end
        S_AXIS_TVALID = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 400) begin @(posedge clk); n++; end
        chk("drain", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_hits"}, arp_hit_count, 32'(mh));
        chk({tag, "_misses"}, arp_miss_count, 32'(mm));
`ifdef ARP_TTL_EXPIRE_EN
        chk({tag, "_expired"}, ttl_expired_count, 32'(me));
`endif
    endtask

    task automatic tbl_wr(input int a, input bit v, input logic [47:0] m, input logic [31:0] ip);
        tbl_wr_req = 1; tbl_wr_addr = AW'(a); tbl_wr_data = {v, m, ip};
        @(posedge clk); #1;
        tbl_wr_req = 0;
        chk("wr_ack", tbl_wr_ack, 1);
        tv[a] = v; tmac[a] = m; tip[a] = ip;
    endtask

    task automatic tbl_rd(input int a, output logic [80:0] d);
        tbl_rd_req = 1; tbl_rd_addr = AW'(a);
        @(posedge clk); #1;
        tbl_rd_req = 0;
        chk("rd_ack", tbl_rd_ack, 1);
        d = tbl_rd_data;
    endtask

    initial begin
        logic [80:0] rd;
        logic [7:0] src;
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        errors++;
        finish_run();
        rd = '0; src = '0;
    end

    initial begin
        logic [80:0] rd;
        logic [7:0] src;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", M_AXIS_TVALID, 0);
        chk("rst_s_tready", S_AXIS_TREADY, 0);
        chk("rst_acks", {tbl_wr_ack, tbl_rd_ack}, 0);
        chk("rst_rd_data", tbl_rd_data, 0);
        chk("rst_counters", {arp_hit_count, arp_miss_count}, 0);
        rstn = 1;
        @(posedge clk); #1;
        chk("idle_s_tready", S_AXIS_TREADY, 1);
        chk_en = 1;

        // Hit on entry 3
        tbl_wr(3, 1, 48'h0011_2233_4455, 32'h0A00_0002);
        send_pkt(3, 1, 32'h0A00_0002, 8'd1, 8'd64, 16'hB1E6, 8'h01, 8'h00, 0);
        drain();
        chk("t1_scan", last_scan, 4);
        chk("t1_dmac", last_hdr[255:208], 48'h0011_2233_4455);
        chk("t1_smac", last_hdr[207:160], 48'h02AA_0000_0001);
        chk("t1_ttl", last_hdr[79:72], 8'd63);
        chk("t1_cksum", last_hdr[63:48], 16'hB2E6);
        chk("t1_dst", last_user[31:24], 8'h04);
        chk("t1_hitcnt", arp_hit_count, 1);

        // Miss, source port 2
        send_pkt(2, 1, 32'h0A00_0009, 8'd0, 8'd20, 16'h1234, 8'h10, 8'h00, 0);
        drain();
        chk("t2_scan", last_scan, 32);
        chk("t2_cksum", last_hdr[63:48], 16'h1234);
        chk("t2_dst", last_user[31:24], 8'h20);
        chk("t2_misscnt", arp_miss_count, 1);

        // Invalid entry 5 must be skipped in favour of entry 7
        tbl_wr(3, 0, 48'h0011_2233_4455, 32'h0A00_0002);
        tbl_wr(5, 0, 48'h0A0A_0A0A_0A05, 32'h0A00_0002);
        tbl_wr(7, 1, 48'h0B0B_0B0B_0B07, 32'h0A00_0002);
        send_pkt(1, 1, 32'h0A00_0002, 8'd3, 8'd9, 16'h0000, 8'h04, 8'h00, 0);
        drain();
        chk("t3_scan", last_scan, 8);
        chk("t3_dmac", last_hdr[255:208], 48'h0B0B_0B0B_0B07);
        tbl_rd(5, rd);
        chk("t3_rd5_valid", rd[80], 0);
        chk("t3_rd5", rd, {1'b0, 48'h0A0A_0A0A_0A05, 32'h0A00_0002});

        // Same-address read and write in one cycle returns old data
        tbl_wr_req = 1; tbl_wr_addr = 5'd7; tbl_wr_data = {1'b1, 48'h0C0C_0C0C_0C07, 32'h0A00_0002};
        tbl_rd_req = 1; tbl_rd_addr = 5'd7;
        @(posedge clk); #1;
        tbl_wr_req = 0; tbl_rd_req = 0;
        tmac[7] = 48'h0C0C_0C0C_0C07;
        chk("rw_same_old", tbl_rd_data, {1'b1, 48'h0B0B_0B0B_0B07, 32'h0A00_0002});
        @(posedge clk); #1;
        chk("acks_pulse", {tbl_wr_ack, tbl_rd_ack}, 0);
        tbl_rd(7, rd);
        chk("rw_new", rd, {1'b1, 48'h0C0C_0C0C_0C07, 32'h0A00_0002});

        // Single-beat packet stalled by egress
        M_AXIS_TREADY = 0;
        send_pkt(1, 0, 32'h0, 8'd0, 8'd5, 16'h5555, 8'h01, 8'h00, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_tvalid", M_AXIS_TVALID, 1);
        M_AXIS_TREADY = 1;
        drain();
        send_pkt(2, 1, 32'h0A00_0002, 8'd0, 8'd30, 16'h0101, 8'h01, 8'h00, 0);
        drain();
        chk("after_stall_dmac", last_hdr[255:208], 48'h0C0C_0C0C_0C07);

        // Checksum end-around carry, counter_reset racing a hit increment
        tbl_wr(0, 1, 48'h0D0D_0D0D_0D00, 32'h0A00_004D);
        chk("pre_crst_hits", arp_hit_count, 3);
        send_pkt(1, 1, 32'h0A00_004D, 8'd2, 8'd64, 16'hFF00, 8'h01, 8'h00, 1);
        drain();
        chk("t5_cksum", last_hdr[63:48], 16'h0001);
        chk("t5_cnt_zero", {arp_hit_count, arp_miss_count}, 0);

        // TTL boundary
        send_pkt(1, 1, 32'h0A00_004D, 8'd0, 8'd1, 16'h0000, 8'h01, 8'h00, 0);
        drain();
`ifdef ARP_TTL_EXPIRE_EN
        chk("ttl1_dst_cpu", last_user[31:24], 8'h02);
        chk("ttl1_ttl", last_hdr[79:72], 8'd1);
        chk("ttl1_expcnt", ttl_expired_count, 1);
        chk("ttl1_hits", arp_hit_count, 0);
`else
        chk("ttl1_ttl", last_hdr[79:72], 8'd0);
        send_pkt(1, 1, 32'h0A00_004D, 8'd0, 8'd0, 16'h0000, 8'h01, 8'h00, 0);
        drain();
        chk("ttl0_ttl", last_hdr[79:72], 8'hFF);
        chk("ttl0_dst", last_user[31:24], 8'h01);
        chk("ttl_hits", arp_hit_count, 2);
`endif
        chk_cnt("ttl");
        send_pkt(1, 1, 32'h0A00_0077, 8'd0, 8'd9, 16'h0000, 8'h01, 8'h00, 0);
        drain();

        // Reset during BODY
        chk_en = 0;
        S_AXIS_TDATA = rnd256(); S_AXIS_TLAST = 0; S_AXIS_TUSER = '0; S_AXIS_TVALID = 1;
        s_lookup_en = 0;
        wait_hs();
        S_AXIS_TDATA = rnd256();
        wait_hs();
        S_AXIS_TDATA = rnd256();
        rstn = 0;
        @(negedge clk);
        chk("rstbody_tvalid_async", M_AXIS_TVALID, 0);
        @(posedge clk); #1;
        S_AXIS_TVALID = 0;
        chk("rstbody_tvalid", M_AXIS_TVALID, 0);
        chk("rstbody_tready", S_AXIS_TREADY, 0);
        chk("rstbody_counters", {arp_hit_count, arp_miss_count}, 0);
        rstn = 1;
        @(posedge clk); #1;
        for (int a = 0; a < DEPTH; a++) begin
            tbl_rd(a, rd);
            chk("rstbody_invalid", rd[80], 0);
            tv[a] = 0;
        end
        expq.delete();
        wait_hdr = 0; mh = 0; mm = 0; me = 0;
        chk_en = 1;

        // Randomized traffic
        rdy_rand = 1;
        for (int it = 0; it < 120; it++) begin
            int nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                tbl_wr($urandom_range(0, DEPTH-1), ($urandom % 4) != 0,
                       {$urandom, 16'($urandom)}, 32'h0A00_0000 + 32'($urandom_range(0, 15)));
            src = ($urandom % 4 == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            send_pkt($urandom_range(1, 4), ($urandom % 8) != 0,
                     32'h0A00_0000 + 32'($urandom_range(0, 19)), 8'($urandom_range(0, 5)),
                     ($urandom % 5 == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom), 16'($urandom),
                     src, ($urandom % 6 == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 0);
            drain();
            chk_cnt("rand");
            if (it % 10 == 0) begin
                int a = $urandom_range(0, DEPTH-1);
                tbl_rd(a, rd);
                chk("rand_rd_valid", rd[80], tv[a]);
            end
        end
        rdy_rand = 0;
        M_AXIS_TREADY = 1;
        finish_run();
    end
endmodule

// File: doc/arp_lookup_seq.md
Name: arp_lookup_seq

Overview:
- Parametrised successor to the router ARP stage in nf10_router_output_port_lookup. Sits after the LPM stage.
- Takes the next-hop/output-queue sideband with each packet's first beat and scans a valid-bit ARP table one entry per cycle.
- On a hit: rewrites dst/src MAC, decrements TTL, updates the IPv4 checksum incrementally. On a miss: redirects to the source port's CPU queue.
- Keeps hit/miss counters and has a register-side table read/write interface.

Parameters:
- C_AXIS_DATA_WIDTH, 256, stream data width; header field positions below are fixed for 256.
- C_AXIS_TUSER_WIDTH, 128, TUSER width.
- SRC_PORT_POS, 16, LSB of the source-port one-hot in TUSER.
- DST_PORT_POS, 24, LSB of the destination-port one-hot in TUSER.
- NUM_PORTS, 4, number of MAC ports (1..4). Port p uses dst bit 2p; its CPU queue uses bit 2p+1.
- TBL_DEPTH, 32, number of ARP entries (power of 2, 2..256).
- TBL_ADDR_W, 5, equal to log2(TBL_DEPTH).

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESETN  in  1  synchronous active-low reset.
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  ingress stream.
- S_AXIS_TREADY  out  1  ingress ready.
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  egress stream.
- M_AXIS_TREADY  in  1  egress ready.
- s_lookup_en  in  1  lookup requested; sampled with the first beat.
- s_nh_ip  in  32  next-hop IP; sampled with the first beat.
- s_oq  in  8  output port index; sampled with the first beat.
- port_macs  in  48*NUM_PORTS  router MAC per port (port p at [48p+47:48p]).
- tbl_wr_req  in  1  table write strobe.
- tbl_wr_addr  in  TBL_ADDR_W  write address.
- tbl_wr_data  in  81  {valid, mac[47:0], ip[31:0]}.
- tbl_wr_ack  out  1  one-cycle write acknowledge.
- tbl_rd_req  in  1  table read strobe.
- tbl_rd_addr  in  TBL_ADDR_W  read address.
- tbl_rd_data  out  81  read data, same format as tbl_wr_data.
- tbl_rd_ack  out  1  one-cycle read acknowledge.
- counter_reset  in  1  clears all counters.
- arp_hit_count  out  32  hit counter.
- arp_miss_count  out  32  miss counter.

Behaviour:
- Reset (AXI_RESETN=0 at a clock edge):
  - state=IDLE; M_AXIS_TVALID=0; S_AXIS_TREADY=0.
  - Both acks 0, tbl_rd_data 0, counters 0.
  - All table valid bits cleared; IP/MAC contents are don't-care.
  - Reset mid-packet abandons the packet; upstream is not re-synchronised.
- State machine:
  - IDLE: S_AXIS_TREADY=1.
    - On S_AXIS_TVALID, capture beat, TUSER and sideband into the header register.
    - Go to SCAN if s_lookup_en=1 and TUSER dst field is 0; otherwise go to SEND_HDR unmodified.
  - SCAN: S_AXIS_TREADY=0. Index i goes 0..TBL_DEPTH-1, one entry per cycle.
    - Hit: valid[i] && ip[i]==nh. Stops at the first (lowest) hit, so scan takes i+1 cycles.
    - Miss: scan takes TBL_DEPTH cycles. Then go to SEND_HDR.
  - SEND_HDR: M_AXIS_TVALID=1 carrying the header register. On M_AXIS_TREADY, go to BODY, or to IDLE if the header beat had TLAST.
  - BODY: combinational pass-through. M_AXIS_TVALID=S_AXIS_TVALID; S_AXIS_TREADY=M_AXIS_TREADY. TLAST accepted → IDLE.
- Hit rewrite (requires s_oq < NUM_PORTS):
  - TDATA[255:208] = table MAC; TDATA[207:160] = port_macs[s_oq].
  - TTL field TDATA[79:72] decremented by 1.
  - Checksum TDATA[63:48] becomes the ones'-complement sum of old checksum + 16'h0100, with end-around carry. Example: 16'hFF00 → 16'h0001.
  - TUSER dst = 1<<(2*s_oq); arp_hit_count += 1.
- Miss handling (also applies when s_oq >= NUM_PORTS):
  - TDATA unchanged.
  - TUSER dst = src_onehot<<1, using the lowest set source bit at an even position.
  - arp_miss_count += 1.
- Counters: wrap modulo 2^32. counter_reset wins over a same-cycle increment.
- Table access:
  - Write: takes effect at the clock edge with tbl_wr_req; tbl_wr_ack pulses high the following cycle.
  - Read: tbl_rd_data and tbl_rd_ack are valid one cycle after tbl_rd_req.
  - Read and write to the same address in the same cycle: the read returns old data.
  - A write during SCAN is seen only if it lands on an index not yet scanned.
- Throughput: one packet in flight. The next header is accepted only after TLAST leaves.

Optional Feature:
- ARP_TTL_EXPIRE_EN defined:
  - On a hit with incoming TTL <= 1, no rewrite is applied; the packet goes to src_onehot<<1 (CPU).
  - This case is counted in an extra output port ttl_expired_count (32-bit, cleared by counter_reset) and is not counted as a hit.
- ARP_TTL_EXPIRE_EN undefined:
  - The port is absent; TTL 1 decrements to 0; TTL 0 wraps to 8'hFF and the packet is still forwarded.

Test Plan:
- Write entry 3 = {1, 00:11:22:33:44:55, 10.0.0.2}; send a 3-beat packet with lookup_en=1, nh=10.0.0.2, oq=1, TTL=64, cksum=16'hB1E6, src port 0.
  - Required: dst MAC 001122334455, src MAC port_macs[1], TTL=63, cksum=16'hB2E6, TUSER dst=8'h04, hit_count=1, first beat 4 scan cycles after acceptance.
- nh=10.0.0.9 not in table, src port 2 (TUSER src=8'h10).
  - Required: data unchanged, TUSER dst=8'h20, miss_count=1, 32 scan cycles.
- Entry 5 holds 10.0.0.2 with valid=0 and entry 7 holds it with valid=1.
  - Required: entry 7's MAC is used. Then rd addr 5 returns valid=0 one cycle later with tbl_rd_ack=1.
- Single-beat packet (TLAST on first beat) with M_AXIS_TREADY low for 5 cycles.
  - Required: TVALID held and data stable; state returns to IDLE after acceptance; next packet is accepted.
- cksum=16'hFF00, hit.
  - Required: cksum=16'h0001. Also counter_reset asserted in the same cycle as a hit increment: both counters read 0.
- AXI_RESETN pulsed low during BODY.
  - Required: TVALID=0, counters 0, all entries invalid. With ARP_TTL_EXPIRE_EN, a TTL=1 hit goes to the CPU queue and ttl_expired_count=1.
